// File: rtl/logic_op_pkg.sv
// Shared types and default sizes for the bitwise logic pipeline.
package logic_op_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    localparam int LOGIC_W_DEF     = 8;
    localparam int LOGIC_CNT_W_DEF = 16;

endpackage

// File: rtl/logic_op_fifo2.sv
// Two-entry synchronous FIFO. The head entry is visible on rdata without a read strobe.
// The caller never pushes when full unless it pops in the same cycle, and never pops when empty.
module logic_op_fifo2 #(
    parameter int PW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [PW-1:0] wdata,
    output logic [PW-1:0] rdata,
    output logic [1:0]    count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) r_wr_ptr <= ~r_wr_ptr;
            if (pop)  r_rd_ptr <= ~r_rd_ptr;
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

endmodule

// File: rtl/logic_op_pipe.sv
// One-stage AND/OR/XOR/NOT pipeline with a 2-entry output skid FIFO.
// Define LOGIC_OP_PARITY_EN to carry result parity through the FIFO onto out_parity.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int W     = LOGIC_W_DEF,
    parameter int CNT_W = LOGIC_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_OP_PARITY_EN
    ,
    output logic             out_parity
`endif
);

`ifdef LOGIC_OP_PARITY_EN
    localparam int PW = W + 3;
`else
    localparam int PW = W + 2;
`endif

    function automatic logic [W-1:0] f_compute(input op_e op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~a;
        endcase
    endfunction

    logic             r_s1_v;
    op_e              r_s1_op;
    logic [W-1:0]     r_s1_a;
    logic [W-1:0]     r_s1_b;
    logic [CNT_W-1:0] r_op_count;

    logic             w_in_xfer;
    logic             w_push;
    logic             w_pop;
    logic [W-1:0]     w_result;
    logic [PW-1:0]    w_wdata;
    logic [PW-1:0]    w_rdata;
    logic [1:0]       w_count;
    logic             w_full;
    logic             w_empty;

    assign w_result = f_compute(r_s1_op, r_s1_a, r_s1_b);
`ifdef LOGIC_OP_PARITY_EN
    assign w_wdata  = {^w_result, r_s1_op, w_result};
`else
    assign w_wdata  = {r_s1_op, w_result};
`endif

    // A full FIFO still accepts S1 when the head leaves this cycle, which lets
    // out_ready reach in_ready combinationally without touching in_valid.
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_s1_v && (!w_full || w_pop);
    assign in_ready  = !rst && (!r_s1_v || w_push);
    assign w_in_xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v  <= 1'b0;
            r_s1_op <= OP_AND;
            r_s1_a  <= '0;
            r_s1_b  <= '0;
        end else if (w_in_xfer) begin
            r_s1_v  <= 1'b1;
            r_s1_op <= op_e'(in_op);
            r_s1_a  <= in_a;
            r_s1_b  <= in_b;
        end else if (w_push) begin
            r_s1_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_pop) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    logic_op_fifo2 #(
        .PW(PW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_pop),
        .wdata(w_wdata),
        .rdata(w_rdata),
        .count(w_count),
        .full (w_full),
        .empty(w_empty)
    );

    // Stale storage is masked so an empty FIFO always presents zeros.
    assign out_valid = (w_count != 2'd0);
    assign out_data  = w_empty ? '0 : w_rdata[W-1:0];
    assign out_op    = w_empty ? 2'b00 : w_rdata[W+1:W];
    assign out_zero  = (out_data == '0);
    assign op_count  = r_op_count;
`ifdef LOGIC_OP_PARITY_EN
    assign out_parity = w_empty ? 1'b0 : w_rdata[W+2];
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: directed vectors push expected results, a monitor pops and compares.
module tb_logic_op_pipe;
    import logic_op_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [1:0]       out_op;
    logic             out_zero;
    logic [CNT_W-1:0] op_count;
`ifdef LOGIC_OP_PARITY_EN
    logic             out_parity;
`endif

    logic_op_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_op   (out_op),
        .out_zero (out_zero),
        .op_count (op_count)
`ifdef LOGIC_OP_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         p;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   op;
        logic         p;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   stalls = 0;
    logic [CNT_W-1:0] mdl_cnt = '0;

    // Hand-computed expected results and parities.
    vec_t single_v = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vec_t stream_v [3] = '{
        '{2'b01, 8'hAA, 8'h55, 8'hFF, 1'b0},
        '{2'b10, 8'hAA, 8'h55, 8'hFF, 1'b0},
        '{2'b11, 8'hAA, 8'h55, 8'h55, 1'b0}
    };
    vec_t bp_v [5] = '{
        '{2'b00, 8'h0F, 8'hF0, 8'h00, 1'b0},
        '{2'b10, 8'h07, 8'h00, 8'h07, 1'b1},
        '{2'b01, 8'h12, 8'h34, 8'h36, 1'b0},
        '{2'b11, 8'h5A, 8'hC3, 8'hA5, 1'b0},
        '{2'b00, 8'hFF, 8'h81, 8'h81, 1'b0}
    };
    vec_t wrap_v = '{2'b01, 8'h01, 8'h02, 8'h03, 1'b0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_vec(input vec_t v);
        exp_t e;
        e.d  = v.d;
        e.op = v.op;
        e.p  = v.p;
        exp_q.push_back(e);
        $display("accept op=%0d a=%02h b=%02h expect=%02h", v.op, v.a, v.b, v.d);
    endtask

    task automatic drive(input vec_t v);
        in_op = v.op;
        in_a  = v.a;
        in_b  = v.b;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        drive(v);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                expect_vec(v);
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mdl_cnt = '0;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    $display("deliver data=%02h op=%0d zero=%0b count=%0d", out_data, out_op,
                             out_zero, op_count);
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_op", 32'(out_op), 32'(e.op));
                    check("out_zero", 32'(out_zero), 32'(e.d == '0));
`ifdef LOGIC_OP_PARITY_EN
                    check("out_parity", 32'(out_parity), 32'(e.p));
`endif
                    check("op_count_run", 32'(op_count), 32'(mdl_cnt));
                end
                mdl_cnt = mdl_cnt + 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int idx;
        int acc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef LOGIC_OP_PARITY_EN
        check("rst_out_parity", 32'(out_parity), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single AND with two-cycle latency
        out_ready = 1'b1;
        send(single_v);
        @(negedge clk);
        check("latency_not_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_valid", 32'(out_valid), 32'd1);
        drain();
        check("op_count_single", 32'(op_count), 32'd1);

        // Back-to-back stream
        stalls = 0;
        foreach (stream_v[i]) send(stream_v[i]);
        check("stream_no_stall", stalls, 32'd0);
        drain();

        // Back-pressure: only three operands fit
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        in_valid = 1'b1;
        drive(bp_v[0]);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_ready) begin
                expect_vec(bp_v[idx]);
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
            if (idx < 5) drive(bp_v[idx]);
        end
        check("bp_accepted", acc, 32'd3);
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            expect_vec(bp_v[idx]);
            idx++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (idx < 5) begin
            send(bp_v[idx]);
            idx++;
        end
        drain();

        // Reset with FIFO full and S1 loaded
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(stream_v[i]);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_op_count", 32'(op_count), 32'd0);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Counter wrap: 17 deliveries on a 4-bit counter
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(wrap_v);
        drain();
        @(negedge clk);
        check("op_count_wrap", 32'(op_count), 32'd1);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
